mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the byte-addressed data-memory port. Sits between the CPU
//  load/store stage and the data memory. Accepts one load/store per handshake and
//  may be misaligned. Splits each request into naturally aligned chunks, issues one
//  chunk per clock and reassembles load data. Returns one completion pulse per request.
// PARAMETERS
//  ADDR_W   64  address width (req_addr, mem_address)
//  DATA_W   64  data width; fixed 8 bytes, little-endian
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       synchronous, active-high reset
//  req_valid        in   1       request present
//  req_ready        out  1       unit can accept; 1 only in IDLE
//  req_write        in   1       1=store, 0=load
//  req_addr         in   64      byte address, any alignment
//  req_size         in   4       bytes: 1,2,4,8
//  req_wdata        in   64      store data, low req_size bytes used
//  req_signed       in   1       load sign-extend request (see CONFIGURATION)
//  resp_valid       out  1       1-cycle completion pulse (loads and stores)
//  resp_rdata       out  64      load result; valid with resp_valid; 0 for stores
//  mem_address      out  64      chunk address, always aligned to mem_xfer_size
//  mem_write_enable out  1       chunk is a write
//  mem_read_enable  out  1       chunk is a read
//  mem_write_data   out  64      chunk bytes packed at bits [8*sz-1:0]
//  mem_xfer_size    out  4       chunk size 1/2/4/8
//  mem_read_data    in   64      combinational read return, chunk bytes at low end
// BEHAVIOUR
//  - FSM: IDLE -> XFER (on req_valid&&req_ready) -> RESP (after last chunk) -> IDLE.
//  - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0.
//    Reset values on the memory port: mem_*_enable=0, mem_address=0, mem_write_data=0, mem_xfer_size=8.
//    The memory port holds these values in IDLE and RESP.
//  - On accept: latch base=req_addr, cur=req_addr, rem=req_size, write, wdata and signed flag.
//    Clear the assembly buffer.
//  - Chunk size: the largest s in {8,4,2,1} with cur%s==0 and s<=rem. Computed combinationally from cur/rem.
//  - Each XFER cycle issues one chunk. Offset off=cur-base (0..7, 3 bits).
//    Store chunk: mem_write_data = wdata>>(8*off); the memory commits at the end of the cycle.
//    Load chunk: at the clock edge, buf[8*(off+k)+:8] <= mem_read_data[8*k+:8] for k<s.
//    Then cur+=s (mod 2^64, wraps silently) and rem-=s. rem==0 -> RESP.
//  - Chunk count 1..4; worst case is size 8 at addr%8==1 (1,2,4,1).
//  - Latency: accept in cycle 0; chunks in cycles 1..N; resp_valid in cycle N+1.
//    req_ready returns in cycle N+2. Aligned access: resp 2 cycles after accept.
//  - resp_rdata = buf masked to the low req_size bytes, then extended (CONFIGURATION).
//  - Illegal req_size (0,3,5-7,>8): accepted and treated as 8.
//  - req_valid while busy: ignored (req_ready=0). Requester must hold the request until accepted.
//  - Reset mid-operation: at the next edge, enter IDLE and drop the memory enables. No resp_valid.
//    Store chunks already committed stay in memory (no rollback).
//  - Never asserts mem_write_enable and mem_read_enable in the same cycle.
// CONFIGURATION
//  Macro MEM_ACCESS_SIGNEXT_EN:
//   defined   -> loads with req_signed=1 sign-extend from bit 8*req_size-1.
//   undefined -> req_signed is ignored; all loads are zero-extended.
//   Size-8 loads are identical either way.
// STRUCTURE
//  - Package mem_access_pkg: state enum typedef {IDLE,XFER,RESP}; XFER_1/2/4/8 size constants.
//    Also holds function chunk_size(cur_addr_lo[2:0], rem[3:0]) returning 4 bits.
//  - One combinational sub-module, mem_chunk_sel: inputs cur[2:0], rem.
//    Outputs chunk size and next rem. Shared by the FSM and by bench assertions.
// TESTING (bench pairs the unit with the team's data memory, clk period 5000)
//  1 Store size 8 @0x10 data 0x1122334455667788 -> one chunk (0x10, sz 8); resp_valid 2 cycles after accept.
//    Then load size 8 @0x10 -> resp_rdata 0x1122334455667788.
//  2 Store size 8 @0x3 data 0x0807060504030201 -> chunks (0x3,1)(0x4,4)(0x8,2)(0xA,1).
//    Then load size 8 @0x3 -> 0x0807060504030201, 4 chunks, resp in cycle 5.
//  3 Bytes 0x80@0x7, 0x01@0x8; load size 2 @0x7 signed=0 -> chunks (0x7,1)(0x8,1); rdata 0x0180.
//  4 Byte 0x80@0x20; load size 1 @0x20 signed=1 -> with macro 0xFFFFFFFFFFFFFF80, without 0x80.
//  5 Store size 8 @0x1; assert reset during 2nd chunk -> next cycle enables 0, req_ready 1, no resp_valid.
//    Byte @0x1 updated; bytes 0x4-0x8 unchanged.
//  6 Load size 4 @0xFFFFFFFFFFFFFFFE -> mem_address sequence 0x..FE (sz 2), then 0x0 (sz 2).
//    Check the sequence only (address is outside memory).
//  All: assert mem_address % mem_xfer_size == 0 whenever an enable is high.
//  All: 1024 random aligned/misaligned requests vs a byte-array model.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Brief    : Shared types, transfer-size constants and the chunk-size helper
//             used by the data-memory access unit.
//  Revision : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] XFER_1 = 4'd1;
    localparam logic [3:0] XFER_2 = 4'd2;
    localparam logic [3:0] XFER_4 = 4'd4;
    localparam logic [3:0] XFER_8 = 4'd8;

    // Largest naturally aligned power-of-two chunk that fits the remaining bytes.
    function automatic logic [3:0] chunk_size(input logic [2:0] cur_addr_lo,
                                              input logic [3:0] rem);
        logic [3:0] s;
        if (cur_addr_lo == 3'd0 && rem >= XFER_8) begin
            s = XFER_8;
        end else if (cur_addr_lo[1:0] == 2'd0 && rem >= XFER_4) begin
            s = XFER_4;
        end else if (!cur_addr_lo[0] && rem >= XFER_2) begin
            s = XFER_2;
        end else begin
            s = XFER_1;
        end
        return s;
    endfunction

    // Any size outside {1,2,4,8} is handled as a full doubleword.
    function automatic logic [3:0] legal_size(input logic [3:0] sz);
        logic [3:0] s;
        case (sz)
            XFER_1, XFER_2, XFER_4, XFER_8: s = sz;
            default:                        s = XFER_8;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_chunk_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mem_chunk_sel
//  Brief    : Combinational chunk selector: picks the next chunk size from the
//             current address low bits and remaining byte count.
//  Revision : 1.0  initial release
// ============================================================================
module mem_chunk_sel
    import mem_access_pkg::*;
(
    input  logic [2:0] cur_i,
    input  logic [3:0] rem_i,
    output logic [3:0] size_o,
    output logic [3:0] rem_next_o
);

    // Chunk size and the byte count left after issuing it.
    always_comb begin
        size_o     = chunk_size(cur_i, rem_i);
        rem_next_o = rem_i - size_o;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : Initiator for the byte-addressed data-memory port. Splits each
//             (possibly misaligned) load/store into aligned chunks, one per
//             clock, reassembles load data and pulses one completion.
//  Config   : MEM_ACCESS_SIGNEXT_EN - when defined, loads with req_signed=1
//             are sign-extended; otherwise all loads are zero-extended.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
);

`ifdef MEM_ACCESS_SIGNEXT_EN
    localparam bit C_SIGNEXT = 1'b1;
`else
    localparam bit C_SIGNEXT = 1'b0;
`endif

    state_e            state_q;
    logic [2:0]        base_lo_q;
    logic [ADDR_W-1:0] cur_q;
    logic [3:0]        rem_q;
    logic [3:0]        size_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              signed_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] buf_d;

    logic [3:0]        chunk_sz;
    logic [3:0]        rem_next;
    logic [2:0]        off;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ext;
    logic [5:0]        sign_bit;

    assign off = cur_q[2:0] - base_lo_q;

    mem_chunk_sel u_chunk_sel (
        .cur_i      (cur_q[2:0]),
        .rem_i      (rem_q),
        .size_o     (chunk_sz),
        .rem_next_o (rem_next)
    );

    // Memory port: drive the current chunk in XFER, idle values otherwise.
    always_comb begin
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_data   = '0;
        mem_xfer_size    = XFER_8;
        if (state_q == XFER) begin
            mem_address      = cur_q;
            mem_write_enable = write_q;
            mem_read_enable  = !write_q;
            mem_write_data   = wdata_q >> {off, 3'b000};
            mem_xfer_size    = chunk_sz;
        end
    end

    // Merge returning chunk bytes into the assembly buffer at the request offset.
    always_comb begin
        logic [3:0] idx;
        idx   = '0;
        buf_d = buf_q;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, off} + 4'(k);
            if (4'(k) < chunk_sz && !idx[3]) begin
                buf_d[{idx[2:0], 3'b000} +: 8] = mem_read_data[8*k +: 8];
            end
        end
    end

    // Response shaping: keep the requested bytes, then optionally sign-extend.
    always_comb begin
        mask     = (size_q == XFER_8) ? '1 : ((DATA_W'(1) << {size_q, 3'b000}) - DATA_W'(1));
        sign_bit = 6'({size_q, 3'b000} - 7'd1);
        ext      = buf_q & mask;
        if (C_SIGNEXT && signed_q && size_q != XFER_8 && buf_q[sign_bit]) begin
            ext = ext | ~mask;
        end
        resp_valid = (state_q == RESP);
        resp_rdata = (state_q == RESP && !write_q) ? ext : '0;
        req_ready  = (state_q == IDLE);
    end

    // Request FSM: latch on accept, step one chunk per cycle, pulse completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_lo_q <= '0;
            cur_q     <= '0;
            rem_q     <= '0;
            size_q    <= XFER_8;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            signed_q  <= 1'b0;
            buf_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q   <= XFER;
                        base_lo_q <= req_addr[2:0];
                        cur_q     <= req_addr;
                        rem_q     <= legal_size(req_size);
                        size_q    <= legal_size(req_size);
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        signed_q  <= req_signed;
                        buf_q     <= '0;
                    end
                end
                XFER: begin
                    cur_q <= cur_q + ADDR_W'(chunk_sz);
                    rem_q <= rem_next;
                    if (!write_q) begin
                        buf_q <= buf_d;
                    end
                    if (rem_next == 4'd0) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Directed and random checks of mem_access_unit paired with a
//             256-byte behavioural data memory.
//  Config   : honours MEM_ACCESS_SIGNEXT_EN for expected load extension.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [3:0]  req_size;
    logic [63:0] req_wdata;
    logic        req_signed;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [63:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #2500 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_wdata        (req_wdata),
        .req_signed       (req_signed),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
    );

    // Behavioural data memory: 256 bytes, address wraps on the low byte.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    always_comb begin
        mem_read_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < mem_xfer_size) begin
                mem_read_data[8*k +: 8] = mem[mem_address[7:0] + 8'(k)];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < mem_xfer_size) begin
                    mem[mem_address[7:0] + 8'(k)] <= mem_write_data[8*k +: 8];
                end
            end
        end
    end

    // Chunk log plus port-level rules checked on every active chunk.
    logic [63:0] ch_addr [$];
    logic [3:0]  ch_size [$];

    always @(negedge clk) begin
        if (mem_write_enable || mem_read_enable) begin
            ch_addr.push_back(mem_address);
            ch_size.push_back(mem_xfer_size);
            n_tests++;
            assert ((mem_address & (64'(mem_xfer_size) - 64'd1)) == 64'd0) else begin
                n_fail++;
                $error("FAIL align: observed addr %h size %0d, required addr multiple of size",
                       mem_address, mem_xfer_size);
            end
            n_tests++;
            assert (!(mem_write_enable && mem_read_enable)) else begin
                n_fail++;
                $error("FAIL excl_en: observed we=%b re=%b, required not both",
                       mem_write_enable, mem_read_enable);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE; returns data and the cycle index of resp_valid.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [3:0] sz,
                          input logic [63:0] wd, input logic sg,
                          output logic [63:0] rd, output int lat);
        ch_addr.delete();
        ch_size.delete();
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = sz;
        req_wdata  = wd;
        req_signed = sg;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        if (!resp_valid) lat = 99;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] exp_load(input logic [63:0] raw, input int n, input logic sg);
        logic [63:0] r;
        logic        ext_en;
`ifdef MEM_ACCESS_SIGNEXT_EN
        ext_en = 1'b1;
`else
        ext_en = 1'b0;
`endif
        r = raw;
        if (ext_en && sg && n < 8 && raw[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic [63:0] rd;
        int          lat;
        logic [7:0]  snap [0:8];
        logic        saw_resp;
        logic [3:0]  size_tab [0:9];
        int          bad;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 4'd8; req_wdata = '0; req_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   64'(req_ready), 64'd1);
        chk("rst_resp_v",  64'(resp_valid), 64'd0);
        chk("rst_rdata",   resp_rdata, 64'd0);
        chk("rst_en",      64'({mem_write_enable, mem_read_enable}), 64'd0);
        chk("rst_addr",    mem_address, 64'd0);
        chk("rst_wdata",   mem_write_data, 64'd0);
        chk("rst_size",    64'(mem_xfer_size), 64'd8);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: aligned store / load
        do_req(1'b1, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, rd, lat);
        chk("t1_st_lat",    64'(lat), 64'd2);
        chk("t1_st_nch",    64'(ch_addr.size()), 64'd1);
        chk("t1_st_addr",   ch_addr[0], 64'h10);
        chk("t1_st_size",   64'(ch_size[0]), 64'd8);
        chk("t1_st_rdata",  rd, 64'd0);
        chk("t1_ready_back", 64'(req_ready), 64'd1);
        do_req(1'b0, 64'h10, 4'd8, 64'd0, 1'b0, rd, lat);
        chk("t1_ld_rdata",  rd, 64'h1122334455667788);
        chk("t1_ld_lat",    64'(lat), 64'd2);

        // 2: worst-case misaligned doubleword
        do_req(1'b1, 64'h3, 4'd8, 64'h0807060504030201, 1'b0, rd, lat);
        chk("t2_st_nch",  64'(ch_addr.size()), 64'd4);
        chk("t2_st_a0",   ch_addr[0], 64'h3);  chk("t2_st_s0", 64'(ch_size[0]), 64'd1);
        chk("t2_st_a1",   ch_addr[1], 64'h4);  chk("t2_st_s1", 64'(ch_size[1]), 64'd4);
        chk("t2_st_a2",   ch_addr[2], 64'h8);  chk("t2_st_s2", 64'(ch_size[2]), 64'd2);
        chk("t2_st_a3",   ch_addr[3], 64'hA);  chk("t2_st_s3", 64'(ch_size[3]), 64'd1);
        chk("t2_st_lat",  64'(lat), 64'd5);
        chk("t2_mem_b3",  64'(mem[3]), 64'h01);
        chk("t2_mem_bA",  64'(mem[10]), 64'h08);
        do_req(1'b0, 64'h3, 4'd8, 64'd0, 1'b0, rd, lat);
        chk("t2_ld_rdata", rd, 64'h0807060504030201);
        chk("t2_ld_nch",   64'(ch_addr.size()), 64'd4);
        chk("t2_ld_lat",   64'(lat), 64'd5);

        // 3: halfword straddling a doubleword boundary
        do_req(1'b1, 64'h7, 4'd1, 64'h80, 1'b0, rd, lat);
        do_req(1'b1, 64'h8, 4'd1, 64'h01, 1'b0, rd, lat);
        do_req(1'b0, 64'h7, 4'd2, 64'd0, 1'b0, rd, lat);
        chk("t3_nch",   64'(ch_addr.size()), 64'd2);
        chk("t3_a0",    ch_addr[0], 64'h7);  chk("t3_s0", 64'(ch_size[0]), 64'd1);
        chk("t3_a1",    ch_addr[1], 64'h8);  chk("t3_s1", 64'(ch_size[1]), 64'd1);
        chk("t3_rdata", rd, 64'h0180);
        chk("t3_lat",   64'(lat), 64'd3);

        // 4: signed byte load
        do_req(1'b1, 64'h20, 4'd1, 64'h80, 1'b0, rd, lat);
        do_req(1'b0, 64'h20, 4'd1, 64'd0, 1'b1, rd, lat);
`ifdef MEM_ACCESS_SIGNEXT_EN
        chk("t4_signed", rd, 64'hFFFFFFFFFFFFFF80);
`else
        chk("t4_signed", rd, 64'h0000000000000080);
`endif
        do_req(1'b0, 64'h20, 4'd1, 64'd0, 1'b0, rd, lat);
        chk("t4_unsigned", rd, 64'h80);

        // Illegal sizes behave as 8
        do_req(1'b0, 64'h10, 4'd3, 64'd0, 1'b1, rd, lat);
        chk("ill3_rdata", rd, 64'h1122334455667788);
        chk("ill3_size",  64'(ch_size[0]), 64'd8);
        do_req(1'b0, 64'h10, 4'd0, 64'd0, 1'b0, rd, lat);
        chk("ill0_rdata", rd, 64'h1122334455667788);

        // 5: reset during the second chunk of a store
        for (int i = 4; i <= 8; i++) snap[i] = mem[i];
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h1; req_size = 4'd8;
        req_wdata = 64'hA1A2A3A4A5A6A7A8; req_signed = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5_chunk1_addr", mem_address, 64'h1);
        @(posedge clk); #1;
        chk("t5_chunk2_addr", mem_address, 64'h2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_en_drop",  64'({mem_write_enable, mem_read_enable}), 64'd0);
        chk("t5_ready",    64'(req_ready), 64'd1);
        reset = 1'b0;
        saw_resp = resp_valid;
        repeat (4) begin
            @(posedge clk); #1;
            saw_resp = saw_resp | resp_valid;
        end
        chk("t5_no_resp", 64'(saw_resp), 64'd0);
        chk("t5_b1",      64'(mem[1]), 64'hA8);
        bad = 0;
        for (int i = 4; i <= 8; i++) if (mem[i] !== snap[i]) bad++;
        chk("t5_b4_8_kept", 64'(bad), 64'd0);

        // 6: address wrap at the top of the space
        do_req(1'b0, 64'hFFFFFFFFFFFFFFFE, 4'd4, 64'd0, 1'b0, rd, lat);
        chk("t6_nch", 64'(ch_addr.size()), 64'd2);
        chk("t6_a0",  ch_addr[0], 64'hFFFFFFFFFFFFFFFE);
        chk("t6_s0",  64'(ch_size[0]), 64'd2);
        chk("t6_a1",  ch_addr[1], 64'h0);
        chk("t6_s1",  64'(ch_size[1]), 64'd2);

        // Random requests against a byte-array model
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        size_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
        for (int t = 0; t < 1024; t++) begin
            logic        wr, sg;
            logic [63:0] addr, wd, raw;
            logic [3:0]  sz;
            int          n;
            wr   = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            addr = 64'($urandom_range(0, 247));
            sz   = size_tab[$urandom_range(0, 9)];
            wd   = {$urandom, $urandom};
            n    = (sz == 4'd1 || sz == 4'd2 || sz == 4'd4) ? int'(sz) : 8;
            do_req(wr, addr, sz, wd, sg, rd, lat);
            chk("rnd_done", 64'(lat < 12), 64'd1);
            if (wr) begin
                for (int k = 0; k < n; k++) ref_mem[addr[7:0] + 8'(k)] = wd[8*k +: 8];
                chk("rnd_st_rdata", rd, 64'd0);
            end else begin
                raw = '0;
                for (int k = 0; k < n; k++) raw[8*k +: 8] = ref_mem[addr[7:0] + 8'(k)];
                chk("rnd_ld_rdata", rd, exp_load(raw, n, sg));
            end
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("rnd_mem_image", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
